// File: rtl/sort_pkg.sv
// ----------------------------------------------------------------------------
// sort_pkg
// Shared definitions for the in-RAM exchange sorter (control unit and
// datapath). Holds the default address width, the derived RAM depth and the
// control FSM state encoding.
// ----------------------------------------------------------------------------
package sort_pkg;

    // Default address width and the RAM depth derived from it. The datapath
    // status flags (zi: i==K-2, zj: j==K-1) are built against SORT_K.
    localparam int SORT_L = 4;
    localparam int SORT_K = 2 ** SORT_L;

    typedef enum logic [3:0] {
        IDLE,
        INIT_J,
        RD_A,
        LD_A,
        RD_B,
        LD_B,
        CMP,
        SWAP1,
        SWAP2,
        NEXT_J,
        NEXT_I,
        DONE
    } sort_state_t;

endpackage : sort_pkg

// File: rtl/sort_ctrl.sv
// ----------------------------------------------------------------------------
// sort_ctrl
// Moore control unit for the in-RAM ascending exchange sort. For every i it
// compares M[i] (held in A) against each M[j], j > i, and swaps the two words
// in RAM whenever A > B. Every output is decoded from the state register
// alone.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   sort_req   in   start request, sampled only in IDLE
//   zi         in   datapath flag: i == K-2
//   zj         in   datapath flag: j == K-1
//   AgtB       in   datapath flag: A > B
//   busy       out  sorter owns the RAM (datapath start port)
//   done       out  one-cycle completion pulse
//   Li, Ei     out  counter i: load 0 / increment
//   Lj, Ej     out  counter j: load i+1 / increment
//   EA, EB     out  load register A / B from RAM read data
//   Csel       out  RAM address select (0: i, 1: j)
//   Bout       out  RAM write data select (0: A, 1: B)
//   Wr         out  RAM write strobe
//   swap_cnt   out  number of swaps in the last run (2*L bits)
//
// Build option
//   SORT_CTRL_SWAP_CNT_EN  when defined, adds the swap_cnt port and its
//                          counter. FSM behaviour is the same either way.
// ----------------------------------------------------------------------------
module sort_ctrl
    import sort_pkg::*;
#(
    parameter int L = SORT_L
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           sort_req,
    input  logic           zi,
    input  logic           zj,
    input  logic           AgtB,
    output logic           busy,
    output logic           done,
    output logic           Li,
    output logic           Ei,
    output logic           Lj,
    output logic           Ej,
    output logic           EA,
    output logic           EB,
    output logic           Csel,
    output logic           Bout,
    output logic           Wr
`ifdef SORT_CTRL_SWAP_CNT_EN
    ,
    output logic [2*L-1:0] swap_cnt
`endif
);

    sort_state_t state_q;
    // Set by a swap: M[i] changed, so A must be re-read before the next
    // compare unless the pass is ending anyway (INIT_J re-reads A then).
    logic        reload_a_q;

`ifdef SORT_CTRL_SWAP_CNT_EN
    localparam logic [2*L-1:0] CNT_ONE = {{(2*L-1){1'b0}}, 1'b1};
    logic [2*L-1:0] swap_cnt_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            reload_a_q <= 1'b0;
`ifdef SORT_CTRL_SWAP_CNT_EN
            swap_cnt_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (sort_req) begin
                        state_q <= INIT_J;
`ifdef SORT_CTRL_SWAP_CNT_EN
                        swap_cnt_q <= '0;
`endif
                    end
                end
                INIT_J: begin
                    reload_a_q <= 1'b0;
                    state_q    <= RD_A;
                end
                RD_A:  state_q <= LD_A;
                LD_A:  state_q <= RD_B;
                RD_B:  state_q <= LD_B;
                LD_B:  state_q <= CMP;
                CMP:   state_q <= AgtB ? SWAP1 : NEXT_J;
                SWAP1: state_q <= SWAP2;
                SWAP2: begin
                    reload_a_q <= 1'b1;
                    state_q    <= NEXT_J;
`ifdef SORT_CTRL_SWAP_CNT_EN
                    swap_cnt_q <= swap_cnt_q + CNT_ONE;
`endif
                end
                NEXT_J: begin
                    // j is incremented here even on the last compare; the
                    // wrapped value is never used because INIT_J reloads j.
                    if (zj) begin
                        state_q <= NEXT_I;
                    end else if (reload_a_q) begin
                        reload_a_q <= 1'b0;
                        state_q    <= RD_A;
                    end else begin
                        state_q <= RD_B;
                    end
                end
                NEXT_I: state_q <= zi ? DONE : INIT_J;
                DONE:   state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Output decode. Each RAM read keeps its address for two states (RD_x,
    // LD_x) so a registered-read RAM has its data ready when the load fires.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        Li   = 1'b0;
        Ei   = 1'b0;
        Lj   = 1'b0;
        Ej   = 1'b0;
        EA   = 1'b0;
        EB   = 1'b0;
        Csel = 1'b0;
        Bout = 1'b0;
        Wr   = 1'b0;
        case (state_q)
            IDLE:   Li = 1'b1;
            INIT_J: begin busy = 1'b1; Lj = 1'b1; end
            RD_A:   begin busy = 1'b1; Csel = 1'b0; end
            LD_A:   begin busy = 1'b1; Csel = 1'b0; EA = 1'b1; end
            RD_B:   begin busy = 1'b1; Csel = 1'b1; end
            LD_B:   begin busy = 1'b1; Csel = 1'b1; EB = 1'b1; end
            CMP:    busy = 1'b1;
            // M[j] <= A
            SWAP1:  begin busy = 1'b1; Csel = 1'b1; Bout = 1'b0; Wr = 1'b1; end
            // M[i] <= B
            SWAP2:  begin busy = 1'b1; Csel = 1'b0; Bout = 1'b1; Wr = 1'b1; end
            NEXT_J: begin busy = 1'b1; Ej = 1'b1; end
            NEXT_I: begin busy = 1'b1; Ei = 1'b1; end
            DONE:   begin done = 1'b1; Li = 1'b1; end
            default: ;
        endcase
    end

`ifdef SORT_CTRL_SWAP_CNT_EN
    assign swap_cnt = swap_cnt_q;
`endif

endmodule : sort_ctrl

// File: tb/tb_sort_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sort_ctrl
// Bench for sort_ctrl: a behavioural datapath (RAM, counters i/j, registers
// A/B) closes the loop around the controller, while a plain exchange-sort
// reference predicts the sorted contents, swap count and run latency.
// ----------------------------------------------------------------------------
module tb_sort_ctrl;
    import sort_pkg::*;

    localparam int K = SORT_K;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, sort_req;
    logic zi, zj, AgtB;
    logic busy, done, Li, Ei, Lj, Ej, EA, EB, Csel, Bout, Wr;
`ifdef SORT_CTRL_SWAP_CNT_EN
    logic [2*SORT_L-1:0] swap_cnt;
`endif

    sort_ctrl #(.L(SORT_L)) dut (
        .clk      (clk),
        .rst      (rst),
        .sort_req (sort_req),
        .zi       (zi),
        .zj       (zj),
        .AgtB     (AgtB),
        .busy     (busy),
        .done     (done),
        .Li       (Li),
        .Ei       (Ei),
        .Lj       (Lj),
        .Ej       (Ej),
        .EA       (EA),
        .EB       (EB),
        .Csel     (Csel),
        .Bout     (Bout),
        .Wr       (Wr)
`ifdef SORT_CTRL_SWAP_CNT_EN
        ,
        .swap_cnt (swap_cnt)
`endif
    );

    // Behavioural datapath with combinational-read RAM and a host write port.
    logic [15:0] mem [K];
    logic [3:0]  i_q, j_q, addr, host_addr;
    logic [15:0] a_q, b_q, rdata, wdata, host_data;
    logic        host_we;

    assign addr  = Csel ? j_q : i_q;
    assign rdata = mem[addr];
    assign wdata = Bout ? b_q : a_q;
    assign zi    = (i_q == 4'(K - 2));
    assign zj    = (j_q == 4'(K - 1));
    assign AgtB  = (a_q > b_q);

    always @(posedge clk) begin
        if (Li)      i_q <= 4'd0;
        else if (Ei) i_q <= i_q + 4'd1;
        if (Lj)      j_q <= i_q + 4'd1;
        else if (Ej) j_q <= j_q + 4'd1;
        if (EA) a_q <= rdata;
        if (EB) b_q <= rdata;
        if (Wr)           mem[addr]      <= wdata;
        else if (host_we) mem[host_addr] <= host_data;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    logic [15:0] stim [K];
    logic [15:0] expd [K];
    int exp_swaps, exp_reloads;

    // Reference: the textbook exchange sort on an array copy. A swap not on
    // the last j forces a 2-cycle A re-read; every swap costs 2 write cycles.
    task automatic ref_sort();
        logic [15:0] t;
        exp_swaps   = 0;
        exp_reloads = 0;
        for (int k = 0; k < K; k++) expd[k] = stim[k];
        for (int a = 0; a < K - 1; a++) begin
            for (int b = a + 1; b < K; b++) begin
                if (expd[a] > expd[b]) begin
                    t = expd[a]; expd[a] = expd[b]; expd[b] = t;
                    exp_swaps++;
                    if (b < K - 1) exp_reloads++;
                end
            end
        end
    endtask

    function automatic int exp_latency();
        return (K - 1) * 4 + (K * (K - 1) / 2) * 4 + 2 * exp_swaps + 2 * exp_reloads;
    endfunction

    task automatic load_ram();
        for (int k = 0; k < K; k++) begin
            host_we   = 1'b1;
            host_addr = 4'(k);
            host_data = stim[k];
            @(posedge clk); #1;
        end
        host_we = 1'b0;
    endtask

    // Waits for done, counting cycles after the accepting edge and Wr pulses.
    task automatic wait_done(input string name);
        int cyc, wrs;
        cyc = 0;
        wrs = 0;
        while (!done && cyc < 3000) begin
            if (Wr) wrs++;
            @(posedge clk); #1;
            cyc++;
        end
        check({name, "_latency"}, cyc, exp_latency());
        check({name, "_wr_pulses"}, wrs, 2 * exp_swaps);
        check({name, "_busy_in_done"}, {31'd0, busy}, 0);
    endtask

    task automatic check_result(input string name);
        for (int k = 0; k < K; k++) check({name, "_ram"}, {16'd0, mem[k]}, {16'd0, expd[k]});
`ifdef SORT_CTRL_SWAP_CNT_EN
        check({name, "_swap_cnt"}, 32'(swap_cnt), exp_swaps);
`endif
    endtask

    task automatic run_case(input string name);
        load_ram();
        ref_sort();
        sort_req = 1'b1;
        @(posedge clk); #1;
        sort_req = 1'b0;
        check({name, "_busy_rise"}, {31'd0, busy}, 1);
        wait_done(name);
        @(posedge clk); #1;
        check({name, "_done_width"}, {31'd0, done}, 0);
        check_result(name);
    endtask

    initial begin
        rst       = 1'b1;
        sort_req  = 1'b0;
        host_we   = 1'b0;
        host_addr = 4'd0;
        host_data = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 0);
        check("reset_done", {31'd0, done}, 0);
        check("reset_Li", {31'd0, Li}, 1);
        check("reset_strobes", {24'd0, Ei, Lj, Ej, EA, EB, Csel, Bout, Wr}, 0);
`ifdef SORT_CTRL_SWAP_CNT_EN
        check("reset_swap_cnt", 32'(swap_cnt), 0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        for (int k = 0; k < K; k++) stim[k] = 16'(k);
        run_case("ascending");

        for (int k = 0; k < K; k++) stim[k] = 16'(k);
        stim[0] = 16'd1;
        stim[1] = 16'd0;
        run_case("one_swap");

        for (int k = 0; k < K; k++) stim[k] = 16'(K - 1 - k);
        run_case("descending");

        for (int k = 0; k < K; k++) stim[k] = 16'hAAAA;
        run_case("all_equal");

        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < K; k++)
                stim[k] = (r == 0) ? 16'($urandom_range(0, 7)) : 16'($urandom);
            run_case("random");
        end

        // Asynchronous reset while in CMP (5 edges after acceptance).
        for (int k = 0; k < K; k++) stim[k] = 16'(K - 1 - k);
        load_ram();
        sort_req = 1'b1;
        @(posedge clk); #1;
        sort_req = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_busy", {31'd0, busy}, 0);
        check("midrst_done", {31'd0, done}, 0);
        check("midrst_Li", {31'd0, Li}, 1);
        check("midrst_Wr", {31'd0, Wr}, 0);
        for (int k = 0; k < K; k++) check("midrst_ram", {16'd0, mem[k]}, {16'd0, stim[k]});
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("midrst_stay_idle", {31'd0, busy}, 0);

        // sort_req held high: back-to-back runs with one IDLE cycle between.
        for (int k = 0; k < K; k++) stim[k] = 16'($urandom);
        load_ram();
        ref_sort();
        sort_req = 1'b1;
        @(posedge clk); #1;
        wait_done("b2b_first");
        check_result("b2b_first");
        @(posedge clk); #1;
        check("b2b_idle_busy", {31'd0, busy}, 0);
        check("b2b_idle_Li", {31'd0, Li}, 1);
        check("b2b_idle_done", {31'd0, done}, 0);
        @(posedge clk); #1;
        check("b2b_initj_busy", {31'd0, busy}, 1);
        check("b2b_initj_Lj", {31'd0, Lj}, 1);
        for (int k = 0; k < K; k++) stim[k] = expd[k];
        ref_sort();
        wait_done("b2b_second");
        sort_req = 1'b0;
        check_result("b2b_second");
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("b2b_no_extra_run", {30'd0, busy, done}, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sort_ctrl
